// File: rtl/uart_led_pkg.sv
// Shared constants, FSM state encoding and frame payload for the UART LED command sequencer.
package uart_led_pkg;

  localparam logic [7:0] HDR = 8'hA5;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  localparam logic [7:0] OP_SET   = 8'h01;
  localparam logic [7:0] OP_CLR   = 8'h02;
  localparam logic [7:0] OP_TOG   = 8'h03;
  localparam logic [7:0] OP_BLINK = 8'h04;
  localparam logic [7:0] OP_READ  = 8'h05;

  typedef enum logic [2:0] {
    S_HDR, S_OP, S_ARG, S_CSUM, S_EXEC, S_TX, S_TXW
  } state_t;

  typedef struct packed {
    logic [7:0] op;
    logic [7:0] arg;
  } frame_t;

  function automatic logic op_known(input logic [7:0] op);
    return (op >= OP_SET) && (op <= OP_READ);
  endfunction

endpackage

// File: rtl/uart_led_cmd_sequencer_if.sv
// Byte-stream link between the UART receiver/transmitter pair and the command sequencer.
interface uart_led_cmd_sequencer_if;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_error;
  logic       tx_busy;
  logic       tx_done;
  logic [7:0] tx_data;
  logic       tx_start;

  modport master (
    output rx_data, rx_done, frame_error, tx_busy, tx_done,
    input  tx_data, tx_start
  );

  modport slave (
    input  rx_data, rx_done, frame_error, tx_busy, tx_done,
    output tx_data, tx_start
  );
endinterface

// File: rtl/led_blink_gen.sv
// Free-running blink phase generator: phase flips every BLINK_HALF clocks.
module led_blink_gen #(
  parameter int unsigned BLINK_HALF = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic phase
);

  localparam int unsigned CW = (BLINK_HALF > 2) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(BLINK_HALF - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt == LAST) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_led_cmd_sequencer.sv
// Framed LED command controller: collects A5/OP/ARG/CSUM frames, executes LED ops,
// and sequences an ACK/NAK (plus optional status byte) back into the transmitter.
module uart_led_cmd_sequencer
  import uart_led_pkg::*;
#(
  parameter int unsigned N_LED       = 8,
  parameter int unsigned TIMEOUT_CYC = 500_000,
  parameter int unsigned BLINK_HALF  = 25_000_000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  uart_led_cmd_sequencer_if.slave  bus,
  output logic [N_LED-1:0]         led,
  output logic                     cmd_ok,
  output logic [7:0]               err_cnt,
  output logic                     busy
);

  localparam int unsigned TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  state_t            state, state_nxt;
  frame_t            frame, frame_nxt;
  logic [N_LED-1:0]  led_state, led_state_nxt;
  logic [N_LED-1:0]  blink_mask, blink_mask_nxt;
  logic [N_LED-1:0]  mask;
  logic [TW-1:0]     to_cnt, to_cnt_nxt;
  logic [7:0]        tx_data_q, tx_data_nxt;
  logic [7:0]        resp2, resp2_nxt;
  logic              second, second_nxt;
  logic              tx_start_q, tx_start_nxt;
  logic              cmd_ok_nxt;
  logic              err_inc;
  logic              phase;
  logic              rx_ok, rx_bad, in_frame, collecting, to_hit, csum_good;

  led_blink_gen #(.BLINK_HALF(BLINK_HALF)) u_blink (
    .clk   (clk),
    .rst_n (rst_n),
    .phase (phase)
  );

  assign rx_ok      = bus.rx_done & ~bus.frame_error;
  assign rx_bad     = bus.rx_done &  bus.frame_error;
  assign in_frame   = state inside {S_OP, S_ARG, S_CSUM};
  assign collecting = in_frame || (state == S_HDR);
  // An arriving byte always beats a timeout expiring in the same cycle.
  assign to_hit     = in_frame && !bus.rx_done && (to_cnt == TO_LAST);
  assign mask       = frame.arg[N_LED-1:0];
  assign csum_good  = (bus.rx_data == (frame.op ^ frame.arg)) && op_known(frame.op);

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = tx_start_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_HDR;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_HDR:  if (rx_ok && bus.rx_data == HDR) state_nxt = S_OP;
      S_OP:   if (rx_bad || to_hit) state_nxt = S_HDR; else if (rx_ok) state_nxt = S_ARG;
      S_ARG:  if (rx_bad || to_hit) state_nxt = S_HDR; else if (rx_ok) state_nxt = S_CSUM;
      S_CSUM: if (rx_bad || to_hit) state_nxt = S_HDR; else if (rx_ok) state_nxt = S_EXEC;
      S_EXEC: state_nxt = S_TX;
      S_TX:   if (!bus.tx_busy) state_nxt = S_TXW;
      S_TXW:  if (bus.tx_done) state_nxt = second ? S_TX : S_HDR;
      default: state_nxt = S_HDR;
    endcase
  end

  // Output / datapath next values; the command executes as the checksum byte lands
  always_comb begin
    frame_nxt      = frame;
    led_state_nxt  = led_state;
    blink_mask_nxt = blink_mask;
    tx_data_nxt    = tx_data_q;
    resp2_nxt      = resp2;
    second_nxt     = second;
    to_cnt_nxt     = '0;
    err_inc        = 1'b0;
    cmd_ok_nxt     = 1'b0;
    tx_start_nxt   = 1'b0;

    if (in_frame && !bus.rx_done && !to_hit) to_cnt_nxt = to_cnt + TW'(1);
    if ((collecting && rx_bad) || to_hit) err_inc = 1'b1;

    unique case (state)
      S_OP:  if (rx_ok) frame_nxt.op  = bus.rx_data;
      S_ARG: if (rx_ok) frame_nxt.arg = bus.rx_data;
      S_CSUM: begin
        if (rx_ok) begin
          if (csum_good) begin
            cmd_ok_nxt  = 1'b1;
            tx_data_nxt = ACK;
            second_nxt  = (frame.op == OP_READ);
            resp2_nxt   = 8'(led_state);
            case (frame.op)
              OP_SET:   led_state_nxt  = led_state | mask;
              OP_CLR:   led_state_nxt  = led_state & ~mask;
              OP_TOG:   led_state_nxt  = led_state ^ mask;
              OP_BLINK: blink_mask_nxt = mask;
              default:  begin end
            endcase
          end else begin
            err_inc     = 1'b1;
            tx_data_nxt = NAK;
            second_nxt  = 1'b0;
          end
        end
      end
      S_TX:  tx_start_nxt = !bus.tx_busy;
      S_TXW: begin
        if (bus.tx_done && second) begin
          tx_data_nxt = resp2;
          second_nxt  = 1'b0;
        end
      end
      default: begin end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame      <= '0;
      led_state  <= '0;
      blink_mask <= '0;
      to_cnt     <= '0;
      tx_data_q  <= '0;
      resp2      <= '0;
      second     <= 1'b0;
      tx_start_q <= 1'b0;
      cmd_ok     <= 1'b0;
      err_cnt    <= '0;
      busy       <= 1'b0;
      led        <= '0;
    end else begin
      frame      <= frame_nxt;
      led_state  <= led_state_nxt;
      blink_mask <= blink_mask_nxt;
      to_cnt     <= to_cnt_nxt;
      tx_data_q  <= tx_data_nxt;
      resp2      <= resp2_nxt;
      second     <= second_nxt;
      tx_start_q <= tx_start_nxt;
      cmd_ok     <= cmd_ok_nxt;
      err_cnt    <= (err_inc && err_cnt != 8'hFF) ? err_cnt + 8'd1 : err_cnt;
      busy       <= (state_nxt != S_HDR);
      led        <= led_state_nxt ^ (blink_mask_nxt & {N_LED{phase}});
    end
  end

endmodule

// File: tb/tb_uart_led_cmd_sequencer.sv
// Bench for uart_led_cmd_sequencer: frame-level model plus per-cycle compare and a transmitter agent.
module tb_uart_led_cmd_sequencer;

  localparam int TO = 20;
  localparam int BH = 4;
  localparam int TX_LEN = 6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] led;
  logic       cmd_ok;
  logic [7:0] err_cnt;
  logic       busy;

  uart_led_cmd_sequencer_if bus_if();

  uart_led_cmd_sequencer #(
    .N_LED       (8),
    .TIMEOUT_CYC (TO),
    .BLINK_HALF  (BH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus_if),
    .led     (led),
    .cmd_ok  (cmd_ok),
    .err_cnt (err_cnt),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Frame-level model state
  logic [7:0] m_state, m_mask, m_err;
  logic       exp_cmd_ok;
  int         n_cmd_ok;
  int         k;
  logic [7:0] exp_q[$];
  logic [7:0] tx_log[$];
  int         tx_left;
  logic [7:0] tx_hold;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_state = '0; m_mask = '0; m_err = '0; exp_cmd_ok = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_err_inc();
    if (m_err != 8'hFF) m_err = m_err + 8'd1;
  endtask

  task automatic model_frame(input logic [7:0] op, input logic [7:0] arg, input logic [7:0] csum);
    if (csum == (op ^ arg) && op >= 8'h01 && op <= 8'h05) begin
      exp_cmd_ok = 1'b1;
      exp_q.push_back(8'h06);
      case (op)
        8'h01:   m_state = m_state | arg;
        8'h02:   m_state = m_state & ~arg;
        8'h03:   m_state = m_state ^ arg;
        8'h04:   m_mask  = arg;
        default: exp_q.push_back(m_state);
      endcase
    end else begin
      model_err_inc();
      exp_q.push_back(8'h15);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic fe);
    @(negedge clk);
    bus_if.rx_data = b; bus_if.rx_done = 1'b1; bus_if.frame_error = fe;
    @(posedge clk); #1;
    bus_if.rx_done = 1'b0; bus_if.frame_error = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [7:0] arg, input logic [7:0] csum);
    send_byte(8'hA5, 1'b0);
    send_byte(op, 1'b0);
    send_byte(arg, 1'b0);
    send_byte(csum, 1'b0);
    model_frame(op, arg, csum);
  endtask

  task automatic wait_idle();
    int n = 0;
    logic idle;
    do begin
      @(negedge clk); n++;
      idle = (busy == 1'b0) && (tx_left == 0) && (exp_q.size() == 0);
    end while (!idle && n < 300);
    chk("idle_reached", 32'(idle), 32'd1);
  endtask

  // Per-cycle compare of LEDs, error counter and command pulse against the model
  initial begin : compare
    logic ph;
    logic [7:0] exp_led;
    k = 0; n_cmd_ok = 0;
    forever begin
      @(posedge clk); #2;
      if (!rst_n) k = 0; else k++;
      ph = (k == 0) ? 1'b0 : 1'(((k - 1) / BH) % 2);
      exp_led = m_state ^ (m_mask & {8{ph}});
      chk("led", 32'(led), 32'(exp_led));
      chk("err_cnt", 32'(err_cnt), 32'(m_err));
      chk("cmd_ok", 32'(cmd_ok), 32'(exp_cmd_ok));
      exp_cmd_ok = 1'b0;
      if (cmd_ok) n_cmd_ok++;
    end
  end

  // Transmitter agent: accepts tx_start, checks bytes against the expected queue
  initial begin : tx_agent
    bus_if.tx_busy = 1'b0; bus_if.tx_done = 1'b0;
    tx_left = 0; tx_hold = '0;
    forever begin
      @(posedge clk); #3;
      bus_if.tx_done = 1'b0;
      if (!rst_n) begin
        tx_left = 0; bus_if.tx_busy = 1'b0;
      end else if (bus_if.tx_start) begin
        chk("tx_start_while_busy", 32'(tx_left), 32'd0);
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL tx_unexpected: got tx_start with 0x%0h, want no transmit at %0t", bus_if.tx_data, $time);
        end else begin
          chk("tx_data", 32'(bus_if.tx_data), 32'(exp_q.pop_front()));
        end
        tx_log.push_back(bus_if.tx_data);
        tx_hold = bus_if.tx_data; tx_left = TX_LEN; bus_if.tx_busy = 1'b1;
      end else if (tx_left > 0) begin
        chk("tx_data_hold", 32'(bus_if.tx_data), 32'(tx_hold));
        tx_left--;
        if (tx_left == 0) begin
          bus_if.tx_done = 1'b1; bus_if.tx_busy = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no completion, want finish before %0t", $time);
    $fatal(1);
  end

  initial begin : stim
    int toggles;
    logic prev;
    rst_n = 1'b0;
    bus_if.rx_data = '0; bus_if.rx_done = 1'b0; bus_if.frame_error = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_err", 32'(err_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tx_start", 32'(bus_if.tx_start), 32'd0);
    chk("rst_tx_data", 32'(bus_if.tx_data), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Non-header bytes are ignored while idle
    send_byte(8'h00, 1'b0);
    send_byte(8'h5A, 1'b0);
    chk("ignored_busy", 32'(busy), 32'd0);

    // 1. SET
    tx_log.delete();
    send_byte(8'hA5, 1'b0);
    chk("hdr_busy", 32'(busy), 32'd1);
    send_byte(8'h01, 1'b0); send_byte(8'h05, 1'b0); send_byte(8'h04, 1'b0);
    model_frame(8'h01, 8'h05, 8'h04);
    wait_idle();
    chk("t1_led", 32'(led), 32'h05);
    chk("t1_cmd_ok_cnt", 32'(n_cmd_ok), 32'd1);
    chk("t1_tx_cnt", 32'(tx_log.size()), 32'd1);
    if (tx_log.size() > 0) chk("t1_tx0", 32'(tx_log[0]), 32'h06);

    // 2. TOGGLE
    send_frame(8'h03, 8'h0F, 8'h0C);
    wait_idle();
    chk("t2_led", 32'(led), 32'h0A);

    // 3. Bad checksum
    tx_log.delete();
    send_frame(8'h02, 8'hFF, 8'h00);
    wait_idle();
    chk("t3_led", 32'(led), 32'h0A);
    chk("t3_err", 32'(err_cnt), 32'd1);
    chk("t3_cmd_ok_cnt", 32'(n_cmd_ok), 32'd2);
    if (tx_log.size() > 0) chk("t3_tx0", 32'(tx_log[0]), 32'h15);

    // 4. READ
    tx_log.delete();
    send_frame(8'h05, 8'h00, 8'h05);
    wait_idle();
    chk("t4_tx_cnt", 32'(tx_log.size()), 32'd2);
    if (tx_log.size() == 2) begin
      chk("t4_tx0", 32'(tx_log[0]), 32'h06);
      chk("t4_tx1", 32'(tx_log[1]), 32'h0A);
    end

    // Unknown opcode is rejected with NAK
    send_frame(8'h07, 8'h00, 8'h07);
    wait_idle();
    chk("unk_err", 32'(err_cnt), 32'd2);

    // 5. Timeout, then frame error, then a good frame
    tx_log.delete();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h01, 1'b0);
    repeat (TO) @(posedge clk);
    #1 model_err_inc();
    @(negedge clk);
    chk("to_busy", 32'(busy), 32'd0);
    send_byte(8'hA5, 1'b1);
    model_err_inc();
    repeat (3) @(negedge clk);
    chk("t5_err", 32'(err_cnt), 32'd4);
    chk("t5_no_tx", 32'(tx_log.size()), 32'd0);
    send_frame(8'h01, 8'h01, 8'h00);
    wait_idle();
    chk("t5_led", 32'(led), 32'h0B);

    // 6. Blink on bit 0
    send_frame(8'h04, 8'h01, 8'h05);
    wait_idle();
    toggles = 0;
    @(negedge clk); prev = led[0];
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (led[0] != prev) toggles++;
      prev = led[0];
    end
    chk("blink_toggles", 32'(toggles), 32'd4);
    send_frame(8'h04, 8'h00, 8'h04);
    wait_idle();
    chk("blink_off_led", 32'(led), 32'h0B);
    repeat (5) @(negedge clk);
    chk("blink_off_led_later", 32'(led), 32'h0B);

    // Error counter saturation via frame errors while idle
    for (int i = 0; i < 260; i++) begin
      send_byte(8'h00, 1'b1);
      model_err_inc();
    end
    @(negedge clk);
    chk("err_sat", 32'(err_cnt), 32'hFF);

    // Reset in the middle of a frame
    send_byte(8'hA5, 1'b0);
    send_byte(8'h01, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_led", 32'(led), 32'd0);
    chk("mid_rst_err", 32'(err_cnt), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_tx_start", 32'(bus_if.tx_start), 32'd0);
    chk("mid_rst_tx_data", 32'(bus_if.tx_data), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_led", 32'(led), 32'd0);

    tx_log.delete();
    send_frame(8'h01, 8'h80, 8'h81);
    wait_idle();
    chk("post_rst_set", 32'(led), 32'h80);
    if (tx_log.size() > 0) chk("post_rst_tx0", 32'(tx_log[0]), 32'h06);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
